// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared func3 codes, FSM state encoding and request legality helper
package dmem_responder_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_WAIT = 2'd1;
   localparam state_t ST_RESP = 2'd2;

   // Unsigned sizes only make sense for loads, so a store with BU/HU is rejected.
   function automatic logic f3_illegal(input logic [2:0] f3, input logic [1:0] lane,
                                       input logic is_wr);
      case (f3)
         F3_B:    f3_illegal = 1'b0;
         F3_H:    f3_illegal = lane[0];
         F3_W:    f3_illegal = (lane != 2'b00);
         F3_BU:   f3_illegal = is_wr;
         F3_HU:   f3_illegal = is_wr | lane[0];
         default: f3_illegal = 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/dmem_responder_bytelane.sv
// rtl/dmem_responder_bytelane.sv - byte-enable/store alignment and load extraction/extension
module dmem_bytelane
   import dmem_responder_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [2:0]        func3,
   input  logic [1:0]        lane,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [DATA_W-1:0] rd_word,
   output logic [3:0]        byte_en,
   output logic [DATA_W-1:0] wr_shifted,
   output logic [DATA_W-1:0] rd_ext
);

   logic [7:0]  rd_b;
   logic [15:0] rd_h;

   always_comb begin
      case (func3[1:0])
         2'b00:   byte_en = 4'b0001 << lane;
         2'b01:   byte_en = 4'b0011 << lane;
         2'b10:   byte_en = 4'b1111;
         default: byte_en = 4'b0000;
      endcase
      wr_shifted = wr_data << {lane, 3'b000};
   end

   always_comb begin
      rd_b = rd_word[{lane, 3'b000} +: 8];
      rd_h = rd_word[{lane[1], 4'b0000} +: 16];
      case (func3)
         F3_B:    rd_ext = {{(DATA_W-8){rd_b[7]}}, rd_b};
         F3_H:    rd_ext = {{(DATA_W-16){rd_h[15]}}, rd_h};
         F3_BU:   rd_ext = {{(DATA_W-8){1'b0}}, rd_b};
         F3_HU:   rd_ext = {{(DATA_W-16){1'b0}}, rd_h};
         default: rd_ext = rd_word;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-request data memory responder with fixed wait states
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int DM_ADDRESS  = 9,
   parameter int DATA_W      = 32,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  wr,
   input  logic                  reade,
   input  logic [DM_ADDRESS-1:0] addr,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic [2:0]            func3,
   output logic                  rsp_valid,
   output logic [DATA_W-1:0]     rd_data,
   output logic                  err,
   output logic                  busy
);

   localparam int         DEPTH    = 2 ** (DM_ADDRESS - 2);
   localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   state_t                 state;
   logic [3:0]             cnt;
   logic [DM_ADDRESS-1:0]  a_addr;
   logic [DATA_W-1:0]      a_data;
   logic [2:0]             a_func3;
   logic                   a_wr;
   logic                   err_q;
   logic [DATA_W-1:0]      rd_q;
   logic [DATA_W-1:0]      mem [DEPTH];

   logic                   in_idle;
   logic                   accept;
   logic                   req_err;
   logic                   commit;
   logic [DM_ADDRESS-1:0]  cur_addr;
   logic [DATA_W-1:0]      cur_data;
   logic [2:0]             cur_func3;
   logic                   cur_wr;
   logic [DM_ADDRESS-3:0]  word_idx;
   logic [3:0]             byte_en;
   logic [DATA_W-1:0]      wr_shifted;
   logic [DATA_W-1:0]      rd_ext;

   assign in_idle = (state == ST_IDLE);
   assign accept  = req_valid && in_idle && (wr || reade);
   assign req_err = f3_illegal(func3, addr[1:0], wr);

   // With zero wait states the commit happens on the accept edge, before capture, so use live inputs.
   assign cur_addr  = in_idle ? addr    : a_addr;
   assign cur_data  = in_idle ? wr_data : a_data;
   assign cur_func3 = in_idle ? func3   : a_func3;
   assign cur_wr    = in_idle ? wr      : a_wr;
   assign word_idx  = cur_addr[DM_ADDRESS-1:2];

   assign commit = (in_idle && accept && !req_err && (WAIT_CYCLES == 0)) ||
                   ((state == ST_WAIT) && (cnt == 4'd0));

   dmem_bytelane #(.DATA_W(DATA_W)) u_bytelane (
      .func3      (cur_func3),
      .lane       (cur_addr[1:0]),
      .wr_data    (cur_data),
      .rd_word    (mem[word_idx]),
      .byte_en    (byte_en),
      .wr_shifted (wr_shifted),
      .rd_ext     (rd_ext)
   );

   // Memory is deliberately outside the reset domain; reset only suppresses a pending write.
   always_ff @(posedge clk) begin
      if (!reset && commit && cur_wr) begin
         for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) mem[word_idx][8*i +: 8] <= wr_shifted[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         cnt     <= 4'd0;
         err_q   <= 1'b0;
         rd_q    <= '0;
         a_addr  <= '0;
         a_data  <= '0;
         a_func3 <= F3_B;
         a_wr    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  a_addr  <= addr;
                  a_data  <= wr_data;
                  a_func3 <= func3;
                  a_wr    <= wr;
                  if (req_err) begin
                     state <= ST_RESP;
                     err_q <= 1'b1;
                     rd_q  <= '0;
                  end else if (WAIT_CYCLES == 0) begin
                     state <= ST_RESP;
                     err_q <= 1'b0;
                     rd_q  <= wr ? '0 : rd_ext;
                  end else begin
                     state <= ST_WAIT;
                     cnt   <= CNT_INIT;
                  end
               end
            end
            ST_WAIT: begin
               if (cnt == 4'd0) begin
                  state <= ST_RESP;
                  err_q <= 1'b0;
                  rd_q  <= a_wr ? '0 : rd_ext;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            default: begin
               state <= ST_IDLE;
               err_q <= 1'b0;
               rd_q  <= '0;
            end
         endcase
      end
   end

   assign req_ready = in_idle;
   assign busy      = !in_idle;
   assign rsp_valid = (state == ST_RESP);
   assign err       = rsp_valid && err_q;
   assign rd_data   = rsp_valid ? rd_q : '0;

endmodule
